// File: rtl/add_sub_serial_if.sv
// Bus for the digit-serial adder/subtractor.
//   en/sub/a/b : start request, mode and operands (sampled by the unit in IDLE)
//   ack        : result consumed (sampled by the unit in DONE)
//   busy/done  : unit status decoded from its state register
//   out/cout/ovf : registered result, carry-out and signed overflow
// The master modport is the requester side; the slave modport is the arithmetic unit.
interface add_sub_serial_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ack;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             ovf;

    modport master (
        output en, sub, a, b, ack,
        input  busy, done, out, cout, ovf
    );

    modport slave (
        input  en, sub, a, b, ack,
        output busy, done, out, cout, ovf
    );
endinterface

// File: rtl/add_sub_serial.sv
// Digit-serial adder/subtractor.
// Captures two WIDTH-bit operands and a mode bit on a start request, then adds DIGIT
// bits per cycle, least significant digit first. The result, carry-out and signed
// overflow are held until acknowledged.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous, active-high reset (aborts any operation in progress)
//   bus : add_sub_serial_if slave modport (en/sub/a/b/ack in, busy/done/out/cout/ovf out)
// Subtraction is done as a + ~b + 1: b is inverted at capture and the carry is seeded with 1.
module add_sub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    add_sub_serial_if.slave  bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if ((WIDTH < 2) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
            $error("add_sub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    logic [1:0]       state_r;
    logic [1:0]       state_next_s;
    logic [WIDTH-1:0] a_reg_r;
    logic [WIDTH-1:0] b_reg_r;
    logic             carry_r;
    logic             mode_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] out_r;
    logic             cout_r;
    logic             ovf_r;
    logic [DIGIT:0]   digit_s;
    logic             last_s;
    logic             ovf_s;
    logic [WIDTH-1:0] out_next_s;
    logic             busy_s;
    logic             done_s;

    // Digit adder, last-digit detect and signed-overflow term for the current digit.
    always_comb begin
        digit_s = {1'b0, a_reg_r[DIGIT-1:0]} + {1'b0, b_reg_r[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry_r};
        last_s  = (count_r == CW'(NDIG - 1));
        // b_reg already holds ~b for subtraction, so one rule covers both modes.
        ovf_s   = (a_reg_r[DIGIT-1] == b_reg_r[DIGIT-1])
               && (digit_s[DIGIT-1] != a_reg_r[DIGIT-1]);
    end

    // Result shift register input: new digit enters at the top, shifting right.
    generate
        if (NDIG == 1) begin : g_one_digit
            always_comb begin
                out_next_s = digit_s[DIGIT-1:0];
            end
        end else begin : g_multi_digit
            always_comb begin
                out_next_s = {digit_s[DIGIT-1:0], out_r[WIDTH-1:DIGIT]};
            end
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; encoding 3 falls back to IDLE.
    always_comb begin
        state_next_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (bus.en) begin
                    state_next_s = S_ADD;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ADD: begin
                if (last_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_ADD;
                end
            end
            S_DONE: begin
                // en is ignored here: a new start needs en in a later IDLE cycle.
                if (bus.ack) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy_s = (state_r != S_IDLE);
        done_s = (state_r == S_DONE);
    end

    // Datapath: operand capture, digit-serial accumulation and result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg_r <= {WIDTH{1'b0}};
            b_reg_r <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            mode_r  <= 1'b0;
            count_r <= {CW{1'b0}};
            out_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.en) begin
                        a_reg_r <= bus.a;
                        b_reg_r <= bus.sub ? ~bus.b : bus.b;
                        carry_r <= bus.sub;
                        mode_r  <= bus.sub;
                        count_r <= {CW{1'b0}};
                        out_r   <= {WIDTH{1'b0}};
                        cout_r  <= 1'b0;
                        ovf_r   <= 1'b0;
                    end
                end
                S_ADD: begin
                    out_r   <= out_next_s;
                    carry_r <= digit_s[DIGIT];
                    a_reg_r <= a_reg_r >> DIGIT;
                    b_reg_r <= b_reg_r >> DIGIT;
                    if (last_s) begin
                        // Count stays at NDIG-1 so it never wraps.
                        cout_r <= digit_s[DIGIT];
                        ovf_r  <= ovf_s;
                    end else begin
                        count_r <= count_r + CW'(1);
                    end
                end
                S_DONE: begin
                    mode_r <= mode_r;
                end
                default: begin
                    mode_r <= mode_r;
                end
            endcase
        end
    end

    assign bus.busy = busy_s;
    assign bus.done = done_s;
    assign bus.out  = out_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_add_sub_serial.sv
// Self-checking bench for add_sub_serial: one W8/D1 and one W16/D4 instance,
// directed cases plus random operations checked against an arithmetic reference model.
module tb_add_sub_serial;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    add_sub_serial_if #(.WIDTH(8))  bus8();
    add_sub_serial_if #(.WIDTH(16)) bus16();

    add_sub_serial #(.WIDTH(8),  .DIGIT(1)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
    add_sub_serial #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    task automatic model(input int w, input longint a, input longint b, input bit s,
                         output longint o, output bit c, output bit v);
        longint full, mask, half, sa, sb, r;
        mask = (64'sd1 <<< w) - 64'sd1;
        half = 64'sd1 <<< (w - 1);
        if (s) begin
            full = a - b;
            c    = (a >= b);
        end else begin
            full = a + b;
            c    = ((full >>> w) & 64'sd1) != 64'sd0;
        end
        o  = full & mask;
        sa = (a >= half) ? a - (64'sd1 <<< w) : a;
        sb = (b >= half) ? b - (64'sd1 <<< w) : b;
        r  = s ? sa - sb : sa + sb;
        v  = (r > half - 64'sd1) || (r < -half);
    endtask

    task automatic drv(input int w, input logic en, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic ack);
        if (w == 8) begin
            bus8.en = en; bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.sub = s; bus8.ack = ack;
        end else begin
            bus16.en = en; bus16.a = a; bus16.b = b; bus16.sub = s; bus16.ack = ack;
        end
    endtask

    function automatic logic [31:0] rd_busy(input int w);
        return (w == 8) ? {31'd0, bus8.busy} : {31'd0, bus16.busy};
    endfunction
    function automatic logic [31:0] rd_done(input int w);
        return (w == 8) ? {31'd0, bus8.done} : {31'd0, bus16.done};
    endfunction
    function automatic logic [31:0] rd_out(input int w);
        return (w == 8) ? {24'd0, bus8.out} : {16'd0, bus16.out};
    endfunction
    function automatic logic [31:0] rd_cout(input int w);
        return (w == 8) ? {31'd0, bus8.cout} : {31'd0, bus16.cout};
    endfunction
    function automatic logic [31:0] rd_ovf(input int w);
        return (w == 8) ? {31'd0, bus8.ovf} : {31'd0, bus16.ovf};
    endfunction

    // Full operation: start, latency check, result check, hold, acknowledge.
    task automatic op(input int w, input logic [15:0] a, input logic [15:0] b, input bit s,
                      input int hold);
        longint o; bit c, v;
        int ndig;
        ndig = (w == 8) ? 8 : 4;
        model(w, longint'(a), longint'(b), s, o, c, v);
        drv(w, 1'b1, a, b, s, 1'b0);
        tick();
        // operands are don't-care from here on; scramble them
        drv(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        chk("busy_start", rd_busy(w), 32'd1);
        for (int i = 1; i < ndig; i++) begin
            tick();
            chk("done_early", rd_done(w), 32'd0);
        end
        tick();
        chk("done_on_time", rd_done(w), 32'd1);
        chk("out", rd_out(w), 32'(o));
        chk("cout", rd_cout(w), {31'd0, c});
        chk("ovf", rd_ovf(w), {31'd0, v});
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("done_hold", rd_done(w), 32'd1);
            chk("out_hold", rd_out(w), 32'(o));
        end
        drv(w, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        tick();
        drv(w, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        chk("busy_after_ack", rd_busy(w), 32'd0);
        chk("done_after_ack", rd_done(w), 32'd0);
        chk("out_kept", rd_out(w), 32'(o));
    endtask

    initial begin
        rst = 1'b1;
        drv(8, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        drv(16, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        for (int w = 8; w <= 16; w += 8) begin
            chk("rst_busy", rd_busy(w), 32'd0);
            chk("rst_done", rd_done(w), 32'd0);
            chk("rst_out", rd_out(w), 32'd0);
            chk("rst_cout", rd_cout(w), 32'd0);
            chk("rst_ovf", rd_ovf(w), 32'd0);
        end

        // Directed cases
        op(8, 16'h5A, 16'h33, 1'b0, 2);
        chk("d_5a33_out", rd_out(8), 32'h8D);
        chk("d_5a33_ovf", rd_ovf(8), 32'd1);
        op(8, 16'hFF, 16'h01, 1'b0, 0);
        chk("d_ff01_cout", rd_cout(8), 32'd1);
        op(8, 16'h80, 16'h01, 1'b1, 0);
        chk("d_8001_out", rd_out(8), 32'h7F);
        op(8, 16'h10, 16'h20, 1'b1, 3);
        chk("d_1020_out", rd_out(8), 32'hF0);
        op(16, 16'h1234, 16'h0FCD, 1'b0, 1);
        chk("d_w16_out", rd_out(16), 32'h2201);

        // Reset on the third ADD cycle aborts the operation
        drv(8, 1'b1, 16'hAA, 16'h55, 1'b0, 1'b0);
        tick();
        drv(8, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", rd_busy(8), 32'd0);
        chk("abort_done", rd_done(8), 32'd0);
        chk("abort_out", rd_out(8), 32'd0);
        op(8, 16'h01, 16'h01, 1'b0, 0);
        chk("after_abort_out", rd_out(8), 32'h02);

        // en pulse during ADD ignored; en+ack in DONE gives one IDLE cycle then a new start
        drv(8, 1'b1, 16'h12, 16'h34, 1'b0, 1'b0);
        tick();
        drv(8, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        tick();
        drv(8, 1'b1, 16'hFF, 16'hFF, 1'b1, 1'b0);
        tick();
        drv(8, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        chk("en_in_add_busy", rd_busy(8), 32'd1);
        chk("en_in_add_done", rd_done(8), 32'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("en_in_add_done_on_time", rd_done(8), 32'd1);
        chk("en_in_add_out", rd_out(8), 32'h46);
        drv(8, 1'b1, 16'h03, 16'h04, 1'b0, 1'b1);
        tick();
        chk("en_ack_idle", rd_busy(8), 32'd0);
        drv(8, 1'b1, 16'h03, 16'h04, 1'b0, 1'b0);
        tick();
        drv(8, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        chk("restart_busy", rd_busy(8), 32'd1);
        chk("restart_done", rd_done(8), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        chk("restart_out", rd_out(8), 32'h07);
        drv(8, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        tick();
        drv(8, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        chk("restart_ack", rd_busy(8), 32'd0);

        // Random operations
        for (int i = 0; i < 20; i++) begin
            op(8, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
               1'($urandom), int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < 12; i++) begin
            op(16, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
